tdm_mux8way: RTL
================

TDM_MUX8WAY -- requirements
Module: tdm_mux8way

Interface
REQ-001 Parameter: FRAME_CNT_W, default 8, width of the completed-frame counter.
REQ-002 Clock and reset SHALL be: clk input 1 (sole clock, rising edge); rst_n input 1 (asynchronous, active-low reset).
REQ-003 a, b, c, d, e, f, g, h input 1 each SHALL carry the eight parallel channel bits (channel 0 = a, ..., channel 7 = h).
REQ-004 load_valid input 1 SHALL indicate that a..h hold a word to be sent.
REQ-005 load_ready output 1 SHALL indicate that the block accepts a word this cycle.
REQ-006 out output 1 SHALL carry the serialized channel bit.
REQ-007 sel output 3 SHALL carry the channel index of out, so that a downstream 8-way demultiplexer can route it.
REQ-008 out_valid output 1 SHALL qualify out and sel.
REQ-009 frame_start output 1 SHALL be high on the first bit (sel=0) of each frame.
REQ-010 frame_count output FRAME_CNT_W SHALL count completed frames.

Function
REQ-011 The block SHALL have two states: IDLE and SHIFT.
REQ-012 A word SHALL be accepted on a rising edge only when load_valid=1 and load_ready=1; {h,g,f,e,d,c,b,a} SHALL then be captured into an internal 8-bit hold register.
REQ-013 load_ready SHALL be 1 in IDLE, 1 in SHIFT when sel=7, and 0 otherwise (combinational from state and sel).
REQ-014 IDLE -> SHIFT SHALL occur on acceptance.
- Starting on edge k, and lasting until edge k+1: out_valid=1, sel=0, frame_start=1, out=captured a.
REQ-015 In SHIFT with sel<7, each edge SHALL increment sel by 1; out SHALL equal hold[sel], registered; frame_start SHALL be 0.
REQ-016 At SHIFT with sel=7, the next edge SHALL complete the frame and increment frame_count.
- If a word is accepted on that same edge: sel wraps to 0, frame_start=1, state stays SHIFT (back-to-back, no gap).
- Otherwise: state goes to IDLE.
REQ-017 In IDLE, out_valid=0, out=0, sel=0 and frame_start=0 SHALL hold.
REQ-018 Changes on a..h after capture SHALL NOT affect the frame in flight.
REQ-019 load_valid while load_ready=0 SHALL be ignored, with no capture and no state change.
REQ-020 frame_count SHALL wrap from 2^FRAME_CNT_W-1 to 0 with no saturation.
REQ-021 All outputs except load_ready SHALL be driven directly from flops.
REQ-022 Latency from acceptance edge to channel-7 bit SHALL be exactly 7 cycles.
- One frame SHALL occupy exactly 8 out_valid cycles.

Reset
REQ-023 While rst_n=0, the following SHALL hold immediately (asynchronous): state=IDLE, out=0, sel=0, out_valid=0, frame_start=0, frame_count=0, hold register=0.
REQ-024 A reset asserted mid-frame SHALL abort the frame.
- The aborted frame SHALL NOT be counted.
- No remaining bits SHALL be emitted after release.
REQ-025 After rst_n deasserts, load_ready SHALL be 1, and the first acceptance SHALL occur on the first rising edge with load_valid=1.

Verification
REQ-026 Single frame, a..h=1,0,1,1,0,0,1,0, one-cycle load_valid:
- sel SHALL step 0..7 over 8 cycles.
- out SHALL be 1,0,1,1,0,0,1,0.
- frame_start SHALL be high only at sel=0.
- frame_count SHALL be 1 afterwards, then IDLE with out_valid=0.
REQ-027 Back-to-back words 8'hFF then 8'h00 with load_valid held high:
- 16 consecutive out_valid cycles SHALL be produced: eight 1s, then eight 0s.
- frame_start SHALL pulse at cycles 0 and 8.
- frame_count SHALL be 2.
REQ-028 Inputs a..h toggled every cycle during a frame captured as 8'hA5:
- out SHALL still serialize 1,0,1,0,0,1,0,1 (a first).
- load_valid pulses at sel=1..6 SHALL be ignored.
REQ-029 rst_n pulsed low at sel=4:
- outputs SHALL be 0 immediately.
- frame_count SHALL be 0.
- No further out_valid SHALL occur until a new load.
REQ-030 Counter wrap: with FRAME_CNT_W=2, five frames SHALL produce frame_count 1,2,3,0,1.
REQ-031 Loopback: out, sel, and in=out_valid fed into an 8-way demultiplexer plus per-channel capture flops SHALL reconstruct a..h exactly for all 256 input words.

Source files
------------

// File: rtl/tdm_mux8way.sv
// Eight-channel TDM serializer: captures a..h as one word and emits it
// a-first, one bit per cycle, with channel index and frame markers.
module tdm_mux8way #(
    parameter int FRAME_CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   a,
    input  logic                   b,
    input  logic                   c,
    input  logic                   d,
    input  logic                   e,
    input  logic                   f,
    input  logic                   g,
    input  logic                   h,
    input  logic                   load_valid,
    output logic                   load_ready,
    output logic                   out,
    output logic [2:0]             sel,
    output logic                   out_valid,
    output logic                   frame_start,
    output logic [FRAME_CNT_W-1:0] frame_count
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [0:0] state;
    logic [7:0] hold;
    logic [7:0] word;
    logic [2:0] next_sel;
    logic       last_bit;
    logic       accept;

    assign word       = {h, g, f, e, d, c, b, a};
    assign next_sel   = sel + 3'd1;
    assign last_bit   = (state == SHIFT) && (sel == 3'd7);
    assign load_ready = (state == IDLE) || last_bit;
    assign accept     = load_valid && load_ready;

    // Acceptance on the last bit reloads without a gap cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            hold        <= 8'd0;
            out         <= 1'b0;
            sel         <= 3'd0;
            out_valid   <= 1'b0;
            frame_start <= 1'b0;
            frame_count <= '0;
        end else begin
            if (last_bit) begin
                frame_count <= frame_count + FRAME_CNT_W'(1);
            end
            if (accept) begin
                state       <= SHIFT;
                hold        <= word;
                sel         <= 3'd0;
                out         <= a;
                out_valid   <= 1'b1;
                frame_start <= 1'b1;
            end else if ((state == SHIFT) && !last_bit) begin
                sel         <= next_sel;
                out         <= hold[next_sel];
                frame_start <= 1'b0;
            end else begin
                state       <= IDLE;
                sel         <= 3'd0;
                out         <= 1'b0;
                out_valid   <= 1'b0;
                frame_start <= 1'b0;
            end
        end
    end

endmodule
